// File: rtl/main_mem_responder_pkg.sv
// Shared cache_ram definitions: responder FSM states, default geometry and
// the cache line layout used by the cache side.
package cache_ram;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam int MEM_DEPTH_LOG2 = 12;
    localparam int MEM_LATENCY    = 3;
    localparam int WORD_W         = 32;

    typedef struct packed {
        logic         valid;
        logic         dirty;
        logic [17:0]  tag;
        logic [127:0] data;
    } cache_block;

    // A word access is legal only when aligned and inside the backing store.
    function automatic logic addr_illegal(input logic [31:0] addr, input int depth_log2);
        logic [31:0] high_bits;
        high_bits = addr >> (depth_log2 + 2);
        return (addr[1:0] != 2'b00) || (high_bits != 32'd0);
    endfunction

endpackage

// File: rtl/main_mem_responder_if.sv
// Request/response channel between the cache (master) and the main-memory
// responder (slave).
interface main_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        wr_mem;
    logic [31:0] cache_to_mem_address;
    logic [31:0] cache_to_mem_data;
    logic [31:0] mem_to_cache_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_err;

    modport master (
        output req_valid,
        output wr_mem,
        output cache_to_mem_address,
        output cache_to_mem_data,
        output rsp_ready,
        input  req_ready,
        input  mem_to_cache_data,
        input  rsp_valid,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  wr_mem,
        input  cache_to_mem_address,
        input  cache_to_mem_data,
        input  rsp_ready,
        output req_ready,
        output mem_to_cache_data,
        output rsp_valid,
        output rsp_err
    );

endinterface

// File: rtl/main_mem_responder_mem_array.sv
// Single-port synchronous word RAM with a registered read port; contents are
// never reset.
module mem_array
    import cache_ram::*;
#(
    parameter int DEPTH_LOG2 = MEM_DEPTH_LOG2,
    parameter int WIDTH      = WORD_W
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] store_r [0:(1 << DEPTH_LOG2) - 1];
    logic [WIDTH-1:0] rdata_r;

    // Write or registered read, one access per enabled edge.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                store_r[addr] <= wdata;
            end else begin
                rdata_r <= store_r[addr];
            end
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/main_mem_responder.sv
// Fixed-latency main-memory responder: accepts one word request, stays BUSY
// for LATENCY edges, then holds the response until the cache takes it.
module main_mem_responder
    import cache_ram::*;
#(
    parameter int DEPTH_LOG2 = MEM_DEPTH_LOG2,
    parameter int LATENCY    = MEM_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    main_mem_responder_if.slave   bus
);

    localparam logic [3:0] LOAD_CNT = 4'(LATENCY - 1);

    mem_state_t            state_r;
    mem_state_t            state_s;
    logic [3:0]            cnt_r;
    logic                  wr_r;
    logic [31:0]           addr_r;
    logic [31:0]           data_r;
    logic [31:0]           rsp_data_r;
    logic                  rsp_valid_r;
    logic                  rsp_err_r;

    logic                  accept_s;
    logic                  commit_s;
    logic                  release_s;
    logic                  req_illegal_s;
    logic                  lat_illegal_s;
    logic                  ram_en_s;
    logic                  ram_we_s;
    logic                  ram_en_gated_s;
    logic                  ram_we_gated_s;
    logic [DEPTH_LOG2-1:0] ram_addr_s;
    logic [31:0]           ram_rdata_s;

    assign req_illegal_s = addr_illegal(bus.cache_to_mem_address, DEPTH_LOG2);
    assign lat_illegal_s = addr_illegal(addr_r, DEPTH_LOG2);

    // The read is launched on the accepting edge so the word is already in
    // the RAM output register by the commit edge; writes wait for commit so
    // an aborted access leaves the store untouched.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        commit_s   = 1'b0;
        release_s  = 1'b0;
        ram_en_s   = 1'b0;
        ram_we_s   = 1'b0;
        ram_addr_s = addr_r[DEPTH_LOG2+1:2];
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    accept_s = 1'b1;
                    state_s  = BUSY;
                    if (!bus.wr_mem && !req_illegal_s) begin
                        ram_en_s   = 1'b1;
                        ram_addr_s = bus.cache_to_mem_address[DEPTH_LOG2+1:2];
                    end else begin
                        ram_en_s   = 1'b0;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == 4'd0) begin
                    commit_s = 1'b1;
                    state_s  = RESP;
                    if (wr_r && !lat_illegal_s) begin
                        ram_en_s = 1'b1;
                        ram_we_s = 1'b1;
                    end else begin
                        ram_en_s = 1'b0;
                        ram_we_s = 1'b0;
                    end
                end else begin
                    state_s = BUSY;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    release_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s   = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Reset on the commit edge must win over the store write.
    assign ram_en_gated_s = ram_en_s & ~rst;
    assign ram_we_gated_s = ram_we_s & ~rst;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request capture and BUSY countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= 4'd0;
            wr_r   <= 1'b0;
            addr_r <= 32'd0;
            data_r <= 32'd0;
        end else if (accept_s) begin
            cnt_r  <= LOAD_CNT;
            wr_r   <= bus.wr_mem;
            addr_r <= bus.cache_to_mem_address;
            data_r <= bus.cache_to_mem_data;
        end else if ((state_r == BUSY) && (cnt_r != 4'd0)) begin
            cnt_r  <= cnt_r - 4'd1;
        end else begin
            cnt_r  <= cnt_r;
        end
    end

    // Response registers, loaded at commit and cleared when consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= 32'd0;
        end else if (commit_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= lat_illegal_s;
            if (lat_illegal_s) begin
                rsp_data_r <= 32'd0;
            end else if (wr_r) begin
                rsp_data_r <= data_r;
            end else begin
                rsp_data_r <= ram_rdata_s;
            end
        end else if (release_s) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= 32'd0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

    mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (32)
    ) u_mem_array (
        .clk   (clk),
        .en    (ram_en_gated_s),
        .we    (ram_we_gated_s),
        .addr  (ram_addr_s),
        .wdata (data_r),
        .rdata (ram_rdata_s)
    );

    assign bus.req_ready         = (state_r == IDLE);
    assign bus.rsp_valid         = rsp_valid_r;
    assign bus.rsp_err           = rsp_err_r;
    assign bus.mem_to_cache_data = rsp_data_r;

endmodule

// File: tb/tb_main_mem_responder.sv
// Bench for main_mem_responder: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level memory model.
module tb_main_mem_responder;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    main_mem_responder_if bus ();
    main_mem_responder_if b1 ();
    main_mem_responder_if b15 ();

    main_mem_responder #(.DEPTH_LOG2(12), .LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
    main_mem_responder #(.DEPTH_LOG2(12), .LATENCY(1))   dut1 (.clk(clk), .rst(rst2), .bus(b1));
    main_mem_responder #(.DEPTH_LOG2(12), .LATENCY(15))  dut15 (.clk(clk), .rst(rst2), .bus(b15));

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: pending access counts down whole edges, then answers.
    logic [31:0] m_mem [0:4095];
    bit          m_busy = 1'b0;
    bit          m_resp = 1'b0;
    int          m_left = 0;
    bit          m_wr = 1'b0;
    logic [31:0] m_addr = 32'd0;
    logic [31:0] m_wdata = 32'd0;
    logic [31:0] m_data = 32'd0;
    bit          m_err = 1'b0;

    function automatic bit model_illegal(input logic [31:0] a);
        return ((a % 4) != 0) || (a >= 32'd16384);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_resp = 1'b0; m_data = 32'd0; m_err = 1'b0;
        end else if (m_resp) begin
            if (bus.rsp_ready) begin
                m_resp = 1'b0; m_data = 32'd0; m_err = 1'b0;
            end
        end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_resp = 1'b1;
                m_err  = model_illegal(m_addr);
                if (m_err) m_data = 32'd0;
                else if (m_wr) begin
                    m_mem[m_addr / 4] = m_wdata;
                    m_data = m_wdata;
                end else m_data = m_mem[m_addr / 4];
            end
        end else if (bus.req_valid) begin
            m_busy = 1'b1; m_left = LAT;
            m_wr = bus.wr_mem; m_addr = bus.cache_to_mem_address; m_wdata = bus.cache_to_mem_data;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_req_ready", {31'd0, bus.req_ready}, {31'd0, !m_busy && !m_resp});
            chk("cyc_rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, m_resp});
            chk("cyc_rsp_err",   {31'd0, bus.rsp_err},   {31'd0, m_err});
            chk("cyc_rsp_data",  bus.mem_to_cache_data,  m_data);
        end
    end

    // Accept spacing monitor for the LATENCY=1 and LATENCY=15 instances.
    int cyc = 0;
    bit sp_en = 1'b0;
    int acc1[$];
    int acc15[$];
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (sp_en) begin
            if (b1.req_valid && b1.req_ready) acc1.push_back(cyc);
            if (b15.req_valid && b15.req_ready) acc15.push_back(cyc);
        end
    end

    // Called just after a rising edge; returns response sampled at end of hold.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold,
                       output logic [31:0] rd, output logic re, output int lat);
        bit ok;
        bus.req_valid = 1'b1; bus.wr_mem = w;
        bus.cache_to_mem_address = a; bus.cache_to_mem_data = d; bus.rsp_ready = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        bus.req_valid = 1'b0; bus.wr_mem = ~w;
        bus.cache_to_mem_address = 32'hFFFF_FFFF; bus.cache_to_mem_data = ~d;
        lat = 0; ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            lat++;
            @(posedge clk); #1;
            if (bus.rsp_valid) ok = 1'b1;
        end
        if (!ok) chk("rsp_timeout", 32'd0, 32'd1);
        for (int n = 0; n < hold; n++) begin
            @(posedge clk); #1;
            chk("hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        rd = bus.mem_to_cache_data; re = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("release_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("release_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    logic [31:0] pre [0:63];
    logic [31:0] rd;
    logic        re;
    int          lat;

    initial begin
        bus.req_valid = 1'b0; bus.wr_mem = 1'b0; bus.rsp_ready = 1'b0;
        bus.cache_to_mem_address = 32'd0; bus.cache_to_mem_data = 32'd0;
        b1.req_valid = 1'b0; b1.wr_mem = 1'b0; b1.rsp_ready = 1'b0;
        b1.cache_to_mem_address = 32'd0; b1.cache_to_mem_data = 32'd0;
        b15.req_valid = 1'b0; b15.wr_mem = 1'b0; b15.rsp_ready = 1'b0;
        b15.cache_to_mem_address = 32'd0; b15.cache_to_mem_data = 32'd0;

        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("reset_rsp_err",   {31'd0, bus.rsp_err},   32'd0);
        chk("reset_rsp_data",  bus.mem_to_cache_data,  32'd0);

        for (int i = 0; i < 64; i++) begin
            pre[i] = $urandom;
            txn(1'b1, 32'(i * 4), pre[i], 0, rd, re, lat);
        end

        // Write then read 0x40.
        txn(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 0, rd, re, lat);
        chk("wr40_latency", 32'(lat), 32'd3);
        chk("wr40_echo", rd, 32'hDEAD_BEEF);
        chk("wr40_err", {31'd0, re}, 32'd0);
        chk("model_mem40", m_mem[16], 32'hDEAD_BEEF);
        txn(1'b0, 32'h0000_0040, 32'h0, 0, rd, re, lat);
        chk("rd40_latency", 32'(lat), 32'd3);
        chk("rd40_data", rd, 32'hDEAD_BEEF);
        chk("rd40_err", {31'd0, re}, 32'd0);

        // Illegal accesses, then confirm word 0 untouched.
        txn(1'b0, 32'h0000_0042, 32'h0, 0, rd, re, lat);
        chk("rd42_err", {31'd0, re}, 32'd1);
        chk("rd42_data", rd, 32'd0);
        txn(1'b0, 32'h0001_0000, 32'h0, 0, rd, re, lat);
        chk("rd10000_err", {31'd0, re}, 32'd1);
        chk("rd10000_data", rd, 32'd0);
        txn(1'b0, 32'h0000_0000, 32'h0, 0, rd, re, lat);
        chk("rd0_data", rd, pre[0]);
        chk("rd0_err", {31'd0, re}, 32'd0);

        // Response held five cycles.
        txn(1'b0, 32'h0000_0008, 32'h0, 5, rd, re, lat);
        chk("hold_data", rd, pre[2]);

        // Reset in the second BUSY cycle of a write to 0x10.
        bus.req_valid = 1'b1; bus.wr_mem = 1'b1;
        bus.cache_to_mem_address = 32'h0000_0010; bus.cache_to_mem_data = 32'h0000_1234;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("abort_rsp_data", bus.mem_to_cache_data, 32'd0);
        @(posedge clk); #1;
        chk("abort_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        txn(1'b0, 32'h0000_0010, 32'h0, 0, rd, re, lat);
        chk("abort_old_value", rd, pre[4]);

        // Free-running randomized traffic, including mid-flight junk and resets.
        for (int c = 0; c < 2500; c++) begin
            int sel;
            @(posedge clk); #1;
            sel = $urandom_range(0, 9);
            if (sel < 7) bus.cache_to_mem_address = 32'($urandom_range(0, 63) * 4);
            else if (sel == 7) bus.cache_to_mem_address = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
            else if (sel == 8) bus.cache_to_mem_address = 32'h0000_4000 << $urandom_range(0, 17);
            else bus.cache_to_mem_address = $urandom | 32'h8000_0000;
            bus.cache_to_mem_data = $urandom;
            bus.wr_mem    = ($urandom_range(0, 1) == 1);
            bus.req_valid = ($urandom_range(0, 9) < 6);
            bus.rsp_ready = ($urandom_range(0, 1) == 1);
            rst           = ($urandom_range(0, 49) == 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
        repeat (20) @(posedge clk);

        // Back-to-back reads at the latency extremes.
        #1 rst2 = 1'b0;
        b1.req_valid = 1'b1; b1.rsp_ready = 1'b1;
        b15.req_valid = 1'b1; b15.rsp_ready = 1'b1;
        sp_en = 1'b1;
        repeat (90) @(posedge clk);
        #1 sp_en = 1'b0;
        chk("l1_accept_count_ok", {31'd0, acc1.size() >= 3}, 32'd1);
        chk("l15_accept_count_ok", {31'd0, acc15.size() >= 3}, 32'd1);
        for (int i = 1; i < acc1.size(); i++) chk("spacing_l1", 32'(acc1[i] - acc1[i-1]), 32'd3);
        for (int i = 1; i < acc15.size(); i++) chk("spacing_l15", 32'(acc15[i] - acc15[i-1]), 32'd17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/main_mem_responder.md
MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 12, the log2 of the word count of the backing store (4096 x 32-bit).
REQ-002 The block SHALL have parameter LATENCY, default 3, the number of BUSY cycles per access; legal range 1..15.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid  input  1  the cache presents a request.
REQ-006 The block SHALL have port req_ready  output  1  the responder can accept a request.
REQ-007 The block SHALL have port wr_mem  input  1  request type: 1 = write-through store, 0 = read/allocate.
REQ-008 The block SHALL have port cache_to_mem_address  input  32  byte address of the request.
REQ-009 The block SHALL have port cache_to_mem_data  input  32  write data.
REQ-010 The block SHALL have port mem_to_cache_data  output  32  response data.
REQ-011 The block SHALL have port rsp_valid  output  1  the response is present.
REQ-012 The block SHALL have port rsp_ready  input  1  the cache consumes the response.
REQ-013 The block SHALL have port rsp_err  output  1  the request was illegal; qualified by rsp_valid.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and RESP; req_ready SHALL equal (state==IDLE).
REQ-015 A request SHALL be accepted on a rising edge with req_valid&&req_ready; address, data and wr_mem are latched and the block enters BUSY with a counter loaded to LATENCY-1.
REQ-016 Inputs other than rsp_ready SHALL be ignored outside IDLE; a changing address or data during BUSY/RESP has no effect.
REQ-017 In BUSY the counter SHALL decrement each edge; on the edge where it equals 0 the access commits and the state goes to RESP, so rsp_valid rises exactly LATENCY edges after the accepting edge.
REQ-018 Word index SHALL be address[DEPTH_LOG2+1:2]; a request is illegal if address[1:0]!=0 or any address bit above DEPTH_LOG2+1 is set.
REQ-019 A legal write SHALL store the latched data at the index on the commit edge; mem_to_cache_data in RESP SHALL echo the written data.
REQ-020 A legal read SHALL present the stored word on mem_to_cache_data throughout RESP.
REQ-021 An illegal request SHALL neither read nor modify the store, and SHALL give rsp_err=1 and mem_to_cache_data=0.
REQ-022 In RESP, rsp_valid, rsp_err and mem_to_cache_data SHALL hold stable until an edge with rsp_ready=1; that edge returns the block to IDLE.
REQ-023 Minimum request spacing SHALL be LATENCY+2 cycles: one IDLE cycle always separates RESP from the next accept.
REQ-024 Outside RESP, rsp_valid and rsp_err SHALL be 0 and mem_to_cache_data SHALL hold 0.

Reset
REQ-025 Reset SHALL force IDLE, counter=0, rsp_valid=0, rsp_err=0, mem_to_cache_data=0, req_ready=1 on the following cycle.
REQ-026 Reset asserted during BUSY before the commit edge SHALL abort the access with no store write; reset coincident with the commit edge wins.
REQ-027 Reset SHALL NOT clear the backing store contents.

Structure
REQ-028 The shared cache_ram package SHALL hold the mem_state_t enum (IDLE/BUSY/RESP) and the constants MEM_DEPTH_LOG2=12 and MEM_LATENCY=3, alongside the existing cache_block typedef.
REQ-029 The backing store SHALL be one sub-module, mem_array: a single-port 2^DEPTH_LOG2 x 32 synchronous RAM with a registered read.

Verification
REQ-030 Write 0x0000_0040 data 0xDEAD_BEEF, then read 0x0000_0040 -> each rsp_valid rises 3 edges after its accept; the write echoes 0xDEAD_BEEF and the read returns 0xDEAD_BEEF with rsp_err=0.
REQ-031 Read 0x0000_0042, then read 0x0001_0000 -> rsp_err=1 and data=0 for both; a following read of 0x0 returns its prior contents unchanged.
REQ-032 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/data stay stable and req_ready stays 0; rsp_ready=1 -> IDLE on the next edge.
REQ-033 Assert rst during the second BUSY cycle of a write to 0x10 with data 0x1234 -> IDLE, outputs 0, and a later read of 0x10 returns the old value.
REQ-034 Issue back-to-back reads with req_valid held high and rsp_ready=1 at LATENCY=1 and LATENCY=15 -> accepts are spaced exactly LATENCY+2 cycles apart.
